dsp48a1_mac_sequencer: RTL and testbench
========================================

Name: dsp48a1_mac_sequencer

Overview:
Controller that sequences one DSP48A1 slice as a vector multiply-accumulator. It accepts a length, then streams signed 18-bit A/B operand pairs over a valid/ready handshake. It drives the slice's data, OPMODE, CE and RST pins so that P = sum(A[i]*B[i]), and returns the 48-bit sum over a valid/ready result port. It sits between a requesting engine and a DSP48A1 configured with A1REG=B1REG=MREG=PREG=OPMODEREG=1 and A0REG=B0REG=CREG=DREG=CARRYINREG=0.

Parameters:
LEN_W, 16, width of the vector-length input.
OP_FIRST, 8'h01, OPMODE for the first element: X=M, Z=0, pre-adder off, add.
OP_ACC, 8'h09, OPMODE for later elements: X=M, Z=P, add.

Ports:
CLK  in  1  clock, rising edge.
RSTN  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a vector; sampled in IDLE only.
len  in  LEN_W  element count, sampled with start.
abort  in  1  synchronous abort of the vector in flight.
in_valid  in  1  operand pair valid.
in_ready  out  1  controller accepts the pair this cycle.
in_a  in  18  signed operand A.
in_b  in  18  signed operand B.
res_valid  out  1  result available.
res_ready  in  1  result consumed.
res_data  out  48  accumulated sum, two's complement, wraps modulo 2^48.
busy  out  1  high in every state except IDLE.
dsp_a, dsp_b  out  18  to DSP A/B; combinationally equal to in_a/in_b.
dsp_opmode  out  8  to DSP OPMODE; registered.
dsp_cea, dsp_ceb  out  1  equal to in_valid & in_ready.
dsp_cem, dsp_ceopmode  out  1  tied high.
dsp_cep  out  1  registered; high only when a valid product reaches P.
dsp_rst  out  1  drives all DSP RST* pins; active high.
dsp_p  in  48  DSP P output.

Behaviour:
- Reset (RSTN low): state IDLE; in_ready=0, res_valid=0, res_data=0, dsp_cep=0, dsp_opmode=OP_FIRST, busy=0, dsp_rst=1.
- dsp_rst stays high for the first cycle after RSTN deasserts, then goes low.
- FSM IDLE:
  - start with len>=1: go to RUN, load remaining count = len.
  - start with len=0: go to DONE with res_data=0; the DSP is not touched.
  - start in any other state is ignored.
- FSM RUN:
  - in_ready=1.
  - Each handshake decrements the count and pushes a valid tag (first flag set for element 0) into a 2-stage tag pipe.
  - The handshake that accepts the last element moves the FSM to DRAIN; in_ready=0 from the next cycle.
  - Gaps in in_valid are legal: tag stages stay invalid, dsp_cep stays low, and P holds.
- Timing for a pair accepted at edge k:
  - edge k: DSP A1/B1 capture the operands.
  - edge k+1: M captures the product; dsp_opmode is registered as OP_FIRST or OP_ACC from the tag.
  - edge k+2: DSP OPMODE reg is active and dsp_cep=1, so P updates.
  - edge k+3: the controller captures dsp_p.
- FSM DRAIN: after the last tag's P update, capture dsp_p into res_data and go to DONE. res_valid is high from edge klast+3.
- FSM DONE: res_valid=1 and res_data is held stable until res_valid & res_ready, then return to IDLE. A start in the cycle of that handshake is ignored.
- abort (any non-IDLE state):
  - Next state is IDLE; the tag pipe is cleared; dsp_cep=0.
  - dsp_rst pulses high for 1 cycle.
  - res_valid drops and no result is produced.
  - abort has priority over every simultaneous handshake.
- Arithmetic: DSP product is signed 36-bit; the accumulate wraps at 48 bits. No saturation and no overflow flag.

Decomposition:
- Shared package dsp48a1_pkg:
  - OPMODE field constants: X_ZERO/X_M/X_P/X_DAB, Z_ZERO/Z_PCIN/Z_P/Z_C, PREADD_EN, PRESUB, CARRY_EN, POSTSUB bits.
  - OP_FIRST and OP_ACC.
  - DSP pipeline-depth constants.
  - FSM state typedef.
- One natural sub-module, dsp48a1_tag_pipe: the valid/first-flag shift register with synchronous clear.

Test Plan:
1. len=3, pairs (2,3),(4,5),(6,7) back-to-back -> res_valid exactly 3 cycles after the third accept, res_data=48'h44 (68).
2. len=2, pairs (-2,3),(1,1) with 2 idle cycles between them -> res_data=48'hFFFFFFFFFFFB (-5); dsp_cep pulses exactly twice.
3. len=0 start -> DONE next cycle, res_data=0, dsp_cea never asserted; hold res_ready=0 for 5 cycles -> res_valid/res_data stable.
4. len=4, abort after 2 accepts -> IDLE next cycle, dsp_rst high 1 cycle, no res_valid. Then len=1, (7,8) -> res_data=56 (no residue).
5. len=2, pairs (131071,131071) twice -> res_data=48'h7FFF80002 (2*(2^17-1)^2).
6. RSTN asserted mid-RUN -> all outputs at reset values immediately; dsp_rst held one cycle past release.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// rtl/dsp48a1_pkg.sv - DSP48A1 OPMODE fields, pipeline depths and sequencer types
package dsp48a1_pkg;

    localparam logic [7:0] X_ZERO    = 8'h00;
    localparam logic [7:0] X_M       = 8'h01;
    localparam logic [7:0] X_P       = 8'h02;
    localparam logic [7:0] X_DAB     = 8'h03;
    localparam logic [7:0] Z_ZERO    = 8'h00;
    localparam logic [7:0] Z_PCIN    = 8'h04;
    localparam logic [7:0] Z_P       = 8'h08;
    localparam logic [7:0] Z_C       = 8'h0C;
    localparam logic [7:0] PREADD_EN = 8'h10;
    localparam logic [7:0] CARRY_EN  = 8'h20;
    localparam logic [7:0] PRESUB    = 8'h40;
    localparam logic [7:0] POSTSUB   = 8'h80;

    localparam logic [7:0] OP_FIRST = X_M | Z_ZERO;
    localparam logic [7:0] OP_ACC   = X_M | Z_P;

    // A1/B1 -> M -> P; the tag pipe covers the M and OPMODE/P register stages
    localparam int AREG_DEPTH      = 1;
    localparam int MREG_DEPTH      = 1;
    localparam int OPMODEREG_DEPTH = 1;
    localparam int PREG_DEPTH      = 1;
    localparam int TAG_DEPTH       = MREG_DEPTH + OPMODEREG_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
    } tag_t;

endpackage

// File: rtl/dsp48a1_tag_pipe.sv
// rtl/dsp48a1_tag_pipe.sv - valid/first tag shift register tracking operands through the DSP
module dsp48a1_tag_pipe
    import dsp48a1_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  logic push_first,
    output tag_t stage0,
    output tag_t stage1
);

    tag_t pipe_q [TAG_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) pipe_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < TAG_DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push ? tag_t'{valid: 1'b1, first: push_first} : tag_t'('0);
            for (int i = 1; i < TAG_DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign stage0 = pipe_q[0];
    assign stage1 = pipe_q[TAG_DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// rtl/dsp48a1_mac_sequencer.sv - sequences one DSP48A1 slice as a vector multiply-accumulator
module dsp48a1_mac_sequencer #(
    parameter int         LEN_W    = 16,
    parameter logic [7:0] OP_FIRST = dsp48a1_pkg::OP_FIRST,
    parameter logic [7:0] OP_ACC   = dsp48a1_pkg::OP_ACC
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);

    import dsp48a1_pkg::*;

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             first_q;
    logic             accept;
    logic             do_abort;
    tag_t             tag0;
    tag_t             tag1;
    logic             unused_first;

    assign accept       = in_valid & in_ready & ~abort;
    assign do_abort     = abort & (state != ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign dsp_a        = in_a;
    assign dsp_b        = in_b;
    assign dsp_cea      = in_valid & in_ready;
    assign dsp_ceb      = in_valid & in_ready;
    assign dsp_cem      = 1'b1;
    assign dsp_ceopmode = 1'b1;
    assign dsp_cep      = tag1.valid;
    assign unused_first = tag0.first ^ tag1.first;

    dsp48a1_tag_pipe u_tag_pipe (
        .clk        (CLK),
        .rst_n      (RSTN),
        .clr        (do_abort),
        .push       (accept),
        .push_first (first_q),
        .stage0     (tag0),
        .stage1     (tag1)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            first_q    <= 1'b0;
            in_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            dsp_opmode <= OP_FIRST;
            dsp_rst    <= 1'b1;
        end else begin
            dsp_rst <= 1'b0;
            if (do_abort) begin
                state      <= ST_IDLE;
                first_q    <= 1'b0;
                in_ready   <= 1'b0;
                res_valid  <= 1'b0;
                dsp_opmode <= OP_FIRST;
                dsp_rst    <= 1'b1;
            end else begin
                // Set at accept so the slice's OPMODE register holds it when M reaches P
                if (accept) dsp_opmode <= first_q ? OP_FIRST : OP_ACC;
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                state    <= ST_RUN;
                                cnt      <= len;
                                first_q  <= 1'b1;
                                in_ready <= 1'b1;
                            end else begin
                                state     <= ST_DONE;
                                res_data  <= '0;
                                res_valid <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            cnt     <= cnt - LEN_W'(1);
                            first_q <= 1'b0;
                            if (cnt == LEN_W'(1)) begin
                                state    <= ST_DRAIN;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Empty pipe means the last P update has already happened
                        if (!tag0.valid && !tag1.valid) begin
                            res_data  <= dsp_p;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb/tb_dsp48a1_mac_sequencer.sv - directed self-checking bench with a DSP48A1 slice model
module tb_dsp48a1_mac_sequencer;

    logic        CLK;
    logic        RSTN;
    logic        start;
    logic [15:0] len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        busy;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea;
    logic        dsp_ceb;
    logic        dsp_cem;
    logic        dsp_ceopmode;
    logic        dsp_cep;
    logic        dsp_rst;
    logic [47:0] dsp_p;

    int checks = 0;
    int errors = 0;
    int cep_cnt = 0;
    int cea_cnt = 0;
    int rv_cnt = 0;

    dsp48a1_mac_sequencer dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .start        (start),
        .len          (len),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_cea      (dsp_cea),
        .dsp_ceb      (dsp_ceb),
        .dsp_cem      (dsp_cem),
        .dsp_ceopmode (dsp_ceopmode),
        .dsp_cep      (dsp_cep),
        .dsp_rst      (dsp_rst),
        .dsp_p        (dsp_p)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DSP48A1 with A1REG=B1REG=MREG=PREG=OPMODEREG=1, synchronous RST
    logic signed [17:0] m_a1;
    logic signed [17:0] m_b1;
    logic signed [35:0] m_m;
    logic [7:0]         m_op;
    logic [47:0]        m_p;

    always @(posedge CLK) begin
        if (dsp_rst) begin
            m_a1 <= '0;
            m_b1 <= '0;
            m_m  <= '0;
            m_op <= '0;
            m_p  <= '0;
        end else begin
            if (dsp_cea) m_a1 <= dsp_a;
            if (dsp_ceb) m_b1 <= dsp_b;
            if (dsp_cem) m_m <= m_a1 * m_b1;
            if (dsp_ceopmode) m_op <= dsp_opmode;
            if (dsp_cep)
                m_p <= ((m_op[3:2] == 2'b10) ? m_p : 48'd0) + {{12{m_m[35]}}, m_m};
        end
    end
    assign dsp_p = m_p;

    always @(negedge CLK) begin
        if (dsp_cep) cep_cnt++;
        if (dsp_cea) cea_cnt++;
        if (res_valid) rv_cnt++;
    end

    task automatic start_vec(input logic [15:0] n);
        start = 1'b1;
        len   = n;
        @(negedge CLK);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_pair in_ready got %0b required 1 within 50 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 40) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if ({in_ready, res_valid, dsp_cep, busy, dsp_rst, dsp_cem, dsp_ceopmode} !== 7'b0000111) begin
            errors++;
            $display("FAIL reset_flags got %b required 0000111",
                     {in_ready, res_valid, dsp_cep, busy, dsp_rst, dsp_cem, dsp_ceopmode});
        end
        checks++;
        if (res_data !== 48'd0 || dsp_opmode !== 8'h01) begin
            errors++;
            $display("FAIL reset_data got %h/%h required 0/01", res_data, dsp_opmode);
        end
        RSTN = 1'b1;
        #1;
        checks++;
        if (dsp_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_rst_hold got %b required 1", dsp_rst);
        end
        @(negedge CLK);
        checks++;
        if (dsp_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_rst_release got %b required 0", dsp_rst);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_vec(16'd3);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_run got ready=%b busy=%b required 1/1", in_ready, busy);
        end
        send_pair(18'd2, 18'd3);
        send_pair(18'd4, 18'd5);
        send_pair(18'd6, 18'd7);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop got %b required 0", in_ready);
        end
        wait_result(cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL b2b_latency got %0d required 3", cyc);
        end
        checks++;
        if (res_data !== 48'h44) begin
            errors++;
            $display("FAIL b2b_data got %h required 000000000044", res_data);
        end
        consume();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release got valid=%b busy=%b required 0/0", res_valid, busy);
        end
    endtask

    task automatic test_gaps();
        int cyc;
        int cep0;
        cep0 = cep_cnt;
        start_vec(16'd2);
        send_pair(-18'sd2, 18'd3);
        @(negedge CLK);
        @(negedge CLK);
        send_pair(18'd1, 18'd1);
        wait_result(cyc);
        checks++;
        if (res_data !== 48'hFFFFFFFFFFFB) begin
            errors++;
            $display("FAIL gaps_data got %h required fffffffffffb", res_data);
        end
        checks++;
        if (cep_cnt - cep0 != 2) begin
            errors++;
            $display("FAIL gaps_cep_pulses got %0d required 2", cep_cnt - cep0);
        end
        consume();
    endtask

    task automatic test_len_zero();
        int cea0;
        cea0 = cea_cnt;
        start_vec(16'd0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 48'd0) begin
            errors++;
            $display("FAIL len0_done got valid=%b data=%h required 1/0", res_valid, res_data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (res_valid !== 1'b1 || res_data !== 48'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL len0_hold cycle %0d got valid=%b data=%h busy=%b required 1/0/1",
                         i, res_valid, res_data, busy);
            end
        end
        checks++;
        if (cea_cnt != cea0) begin
            errors++;
            $display("FAIL len0_cea got %0d required 0", cea_cnt - cea0);
        end
        consume();
    endtask

    task automatic test_abort();
        int cyc;
        int rv0;
        rv0 = rv_cnt;
        start_vec(16'd4);
        send_pair(18'd9, 18'd9);
        send_pair(18'd5, 18'd5);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || dsp_rst !== 1'b1 || dsp_cep !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b ready=%b rst=%b cep=%b required 0/0/1/0",
                     busy, in_ready, dsp_rst, dsp_cep);
        end
        @(negedge CLK);
        checks++;
        if (dsp_rst !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_pulse got %b required 0", dsp_rst);
        end
        repeat (5) @(negedge CLK);
        checks++;
        if (rv_cnt != rv0) begin
            errors++;
            $display("FAIL abort_no_result got %0d required 0", rv_cnt - rv0);
        end
        start_vec(16'd1);
        send_pair(18'd7, 18'd8);
        wait_result(cyc);
        checks++;
        if (res_data !== 48'd56 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_next_data got %h valid=%b required 000000000038/1", res_data, res_valid);
        end
        consume();
    endtask

    task automatic test_max_operands();
        int cyc;
        start_vec(16'd2);
        send_pair(18'd131071, 18'd131071);
        send_pair(18'd131071, 18'd131071);
        wait_result(cyc);
        checks++;
        if (res_data !== 48'h0007FFF80002) begin
            errors++;
            $display("FAIL max_data got %h required 0007fff80002", res_data);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        start_vec(16'd3);
        send_pair(18'd3, 18'd3);
        RSTN = 1'b0;
        #1;
        checks++;
        if ({in_ready, res_valid, dsp_cep, busy, dsp_rst} !== 5'b00001 ||
            dsp_opmode !== 8'h01 || res_data !== 48'd0) begin
            errors++;
            $display("FAIL midrun_reset got %b op=%h data=%h required 00001/01/0",
                     {in_ready, res_valid, dsp_cep, busy, dsp_rst}, dsp_opmode, res_data);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        #1;
        checks++;
        if (dsp_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrun_rst_hold got %b required 1", dsp_rst);
        end
        @(negedge CLK);
        checks++;
        if (dsp_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_rst_release got rst=%b busy=%b required 0/0", dsp_rst, busy);
        end
    endtask

    initial begin
        RSTN      = 1'b0;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len_zero();
        test_abort();
        test_max_operands();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
